// File: rtl/imem_loader_pkg.sv
// Shared types and framing constants for the instruction-memory loader.
// The loader turns a framed byte stream (length, payload words, checksum)
// into 32-bit instruction-memory writes while the CPU is held in reset.
package imem_loader_pkg;

    // Session states, in stream order, plus the two terminal states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // Framing: a 16-bit big-endian word count, big-endian 32-bit words,
    // then one XOR checksum byte covering the payload bytes only.
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int LEN_W          = 16;
    localparam int BYTES_PER_WORD = 4;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);
    localparam logic [BYTE_W-1:0] CSUM_SEED = '0;

    // True when an announced program length exceeds the loader's capacity.
    function automatic logic len_oversize(input logic [LEN_W-1:0] len,
                                          input int unsigned      max_words);
        return 32'(len) > max_words;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Bundle of the loader's control, byte-stream and memory-write signals.
// The loader uses the slave view; whatever feeds the stream and owns the
// instruction memory uses the master view.
interface imem_loader_if #(
    parameter int ADDR_W = 10
) ();
    import imem_loader_pkg::*;

    logic                start;
    logic                in_valid;
    logic [BYTE_W-1:0]   in_data;
    logic                in_ready;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_wdata;
    logic                cpu_hold;
    logic                load_done;
    logic                load_err;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output cpu_hold, load_done, load_err
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_hold, load_done, load_err
    );

endinterface

// File: rtl/imem_loader_asm.sv
// Payload word assembler: counts bytes within a word, builds the big-endian
// 32-bit word and keeps the running XOR of every payload byte.
// The completed word is presented combinationally with the 4th byte so the
// parent can register it into the memory write on the same edge.
module imem_loader_asm
    import imem_loader_pkg::*;
(
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              clear,      // start of a new session
    input  logic              byte_en,    // accepted payload byte
    input  logic [BYTE_W-1:0] byte_in,
    output logic              word_done,  // byte_in completes a word
    output logic [WORD_W-1:0] word,       // valid while word_done
    output logic [BYTE_W-1:0] xsum        // XOR of payload bytes so far
);

    logic [BCNT_W-1:0]        byte_cnt;
    logic [WORD_W-BYTE_W-1:0] shift_q;    // first three bytes of the word
    logic [BYTE_W-1:0]        xsum_q;

    // Byte position, partial word and checksum accumulation.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            shift_q  <= '0;
            xsum_q   <= CSUM_SEED;
        end else if (clear) begin
            byte_cnt <= '0;
            shift_q  <= '0;
            xsum_q   <= CSUM_SEED;
        end else if (byte_en) begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            byte_cnt <= byte_cnt + 1'b1;
            shift_q  <= {shift_q[WORD_W-2*BYTE_W-1:0], byte_in};
            xsum_q   <= xsum_q ^ byte_in;
        end
    end

    // The 4th byte is appended directly rather than waiting for the shift.
    always_comb begin
        word_done = byte_en && (byte_cnt == BCNT_W'(BYTES_PER_WORD - 1));
        word      = {shift_q, byte_in};
        xsum      = xsum_q;
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader top level. Parses the framed byte stream,
// writes each assembled word to instruction memory and releases the CPU
// only after the checksum has been verified. A failed load keeps the CPU
// held so a corrupt image can never execute.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic          clk1,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);

    // The whole program must be addressable.
    if (MAX_WORDS > (1 << ADDR_W)) begin : g_bad_cfg
        $error("imem_loader: MAX_WORDS exceeds 2**ADDR_W");
    end

    state_t             state;
    state_t             state_nxt;
    logic               accept;       // byte transfer this cycle
    logic               start_take;   // start honoured this cycle
    logic [LEN_W-1:0]   len_q;        // announced word count
    logic [LEN_W-1:0]   len_full;     // count including the LEN_LO byte
    logic [LEN_W-1:0]   word_cnt;     // index of the word being assembled
    logic               last_word;

    logic               asm_en;
    logic               word_done;
    logic [WORD_W-1:0]  word;
    logic [BYTE_W-1:0]  xsum;

    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [WORD_W-1:0]  mem_wdata_q;
    logic               load_done_q;

    assign accept     = bus.in_valid && bus.in_ready;
    assign start_take = bus.start &&
                        (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign len_full   = {len_q[LEN_W-1:BYTE_W], bus.in_data};
    assign last_word  = (word_cnt == len_q - 1'b1);
    assign asm_en     = (state == ST_DATA) && accept;

    imem_loader_asm u_asm (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .clear     (start_take),
        .byte_en   (asm_en),
        .byte_in   (bus.in_data),
        .word_done (word_done),
        .word      (word),
        .xsum      (xsum)
    );

    // State register.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; bytes only move the FSM when actually accepted.
    always_comb begin
        // NOTE: default first so no path through the case infers a latch.
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_take) state_nxt = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (accept) state_nxt = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (accept) begin
                    if (len_full == '0)                      state_nxt = ST_CSUM;
                    else if (len_oversize(len_full, MAX_WORDS)) state_nxt = ST_ERR;
                    else                                     state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_done && last_word) state_nxt = ST_CSUM;
            end
            ST_CSUM: begin
                if (accept) state_nxt = (bus.in_data == xsum) ? ST_DONE : ST_ERR;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs; the CPU runs only after a verified load.
    always_comb begin
        bus.in_ready = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
                       (state == ST_DATA)   || (state == ST_CSUM);
        bus.cpu_hold = (state != ST_DONE);
        bus.load_err = (state == ST_ERR);
    end

    // Length capture, word indexing, registered memory write and done pulse.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= '0;
            word_cnt    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            load_done_q <= 1'b0;
        end else begin
            if (state == ST_LEN_HI && accept) len_q[LEN_W-1:BYTE_W] <= bus.in_data;
            if (state == ST_LEN_LO && accept) len_q[BYTE_W-1:0]     <= bus.in_data;

            // DATA is left on the last word, so the index never wraps.
            if (start_take)     word_cnt <= '0;
            else if (word_done) word_cnt <= word_cnt + 1'b1;

            mem_we_q <= word_done;
            if (word_done) begin
                mem_addr_q  <= ADDR_W'(word_cnt);
                mem_wdata_q <= word;
            end

            load_done_q <= (state != ST_DONE) && (state_nxt == ST_DONE);
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.load_done = load_done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized bench for imem_loader. Expected writes and
// outcomes come from a stream-level model that parses the framed byte
// stream directly.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 1024;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clk1 = 1'b0;
    logic rst_n;
    always #5 clk1 = ~clk1;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] stream[$];
    wr_t        seen[$];
    wr_t        exp_writes[$];
    bit         exp_ok;
    int         done_cnt = 0;

    // Record memory writes and done pulses mid-cycle.
    always @(negedge clk1) begin
        if (bus.mem_we) seen.push_back('{bus.mem_addr, bus.mem_wdata});
        if (bus.load_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: parse the stream as framed by length, words and checksum.
    task automatic model();
        int         n;
        logic [7:0] cs;
        logic [31:0] w;
        exp_writes.delete();
        n  = {stream[0], stream[1]};
        cs = 8'h00;
        if (n > MAX_WORDS) begin
            exp_ok = 1'b0;
            return;
        end
        for (int k = 0; k < n; k++) begin
            w = 32'(stream[2+4*k]) * 32'h0100_0000 + 32'(stream[3+4*k]) * 32'h0001_0000 +
                32'(stream[4+4*k]) * 32'h0000_0100 + 32'(stream[5+4*k]);
            for (int b = 0; b < 4; b++) cs = cs ^ stream[2+4*k+b];
            exp_writes.push_back('{ADDR_W'(k), w});
        end
        exp_ok = (stream[2+4*n] == cs);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk1); #1;
        bus.start = 1'b0;
    endtask

    // Send the first n_bytes of the stream with optional random idle gaps;
    // start is also raised alongside byte start_at (-1 for never).
    task automatic send(input int n_bytes, input int gap_pct, input int start_at);
        int w;
        for (int i = 0; i < n_bytes; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                bus.in_valid = 1'b0;
                @(posedge clk1); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = stream[i];
            bus.start    = (i == start_at);
            w = 0;
            while (!bus.in_ready && w < 20) begin
                @(posedge clk1); #1;
                w++;
            end
            if (!bus.in_ready) begin
                check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
                bus.in_valid = 1'b0;
                bus.start    = 1'b0;
                return;
            end
            @(posedge clk1); #1;
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic verify(input string tag);
        check({tag, "_nwrites"}, 64'(seen.size()), 64'(exp_writes.size()));
        for (int i = 0; i < exp_writes.size(); i++) begin
            if (i < seen.size()) begin
                check($sformatf("%s_addr%0d", tag, i), 64'(seen[i].addr), 64'(exp_writes[i].addr));
                check($sformatf("%s_data%0d", tag, i), 64'(seen[i].data), 64'(exp_writes[i].data));
            end
        end
        check({tag, "_done_cnt"}, 64'(done_cnt), exp_ok ? 64'd1 : 64'd0);
        check({tag, "_load_err"}, 64'(bus.load_err), exp_ok ? 64'd0 : 64'd1);
        check({tag, "_cpu_hold"}, 64'(bus.cpu_hold), exp_ok ? 64'd0 : 64'd1);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    endtask

    task automatic run_load(input string tag, input int gap_pct, input int start_at);
        seen.delete();
        done_cnt = 0;
        model();
        do_start();
        send(stream.size(), gap_pct, start_at);
        repeat (3) @(posedge clk1);
        #1;
        verify(tag);
    endtask

    initial begin
        int         n;
        logic [7:0] cs;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #1;
        check("rst_in_ready",  64'(bus.in_ready),  64'd0);
        check("rst_mem_we",    64'(bus.mem_we),    64'd0);
        check("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_cpu_hold",  64'(bus.cpu_hold),  64'd1);
        check("rst_load_done", 64'(bus.load_done), 64'd0);
        check("rst_load_err",  64'(bus.load_err),  64'd0);
        repeat (2) @(negedge clk1);
        rst_n = 1'b1;
        @(posedge clk1); #1;
        check("idle_in_ready", 64'(bus.in_ready), 64'd0);

        // Nominal two-word load.
        stream = '{8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h05, 8'h28, 8'h02, 8'h00, 8'h03, 8'h05};
        run_load("valid", 0, -1);

        // Same stream with a corrupted checksum byte.
        stream[10] = 8'h04;
        run_load("badcsum", 0, -1);

        // Empty program goes straight to the checksum byte.
        stream = '{8'h00, 8'h00, 8'h00};
        run_load("empty", 0, -1);

        // Oversized length is rejected right after LEN_LO.
        stream = '{8'h04, 8'h01};
        seen.delete();
        done_cnt = 0;
        model();
        do_start();
        send(2, 0, -1);
        check("oversize_err_now",   64'(bus.load_err), 64'd1);
        check("oversize_ready_now", 64'(bus.in_ready), 64'd0);
        repeat (3) @(posedge clk1);
        #1;
        verify("oversize");

        // Throttled source, with a stray start mid-payload that must be ignored.
        stream = '{8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h05, 8'h28, 8'h02, 8'h00, 8'h03, 8'h05};
        run_load("throttled", 40, 5);

        // Random programs, good and bad checksums, random gaps.
        for (int it = 0; it < 8; it++) begin
            n = int'($urandom_range(1, 6));
            stream.delete();
            stream.push_back(8'h00);
            stream.push_back(8'(n));
            cs = 8'h00;
            for (int b = 0; b < 4 * n; b++) begin
                stream.push_back(8'($urandom));
                cs = cs ^ stream[stream.size() - 1];
            end
            if ($urandom_range(1) == 0) cs = cs ^ 8'(1 << $urandom_range(7));
            stream.push_back(cs);
            run_load($sformatf("rand%0d", it), 25, -1);
        end

        // Reset after the 6th byte: word 0 lands, word 1 never does.
        stream = '{8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h05, 8'h28, 8'h02, 8'h00, 8'h03, 8'h05};
        seen.delete();
        done_cnt = 0;
        model();
        do_start();
        send(6, 0, -1);
        bus.in_valid = 1'b1;
        bus.in_data  = stream[6];
        @(negedge clk1); #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("abort_mem_we",   64'(bus.mem_we),   64'd0);
        check("abort_cpu_hold", 64'(bus.cpu_hold), 64'd1);
        check("abort_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (2) @(negedge clk1);
        rst_n = 1'b1;
        repeat (3) @(posedge clk1);
        #1;
        check("abort_nwrites",  64'(seen.size()), 64'd1);
        if (seen.size() > 0) begin
            check("abort_addr0", 64'(seen[0].addr), 64'(exp_writes[0].addr));
            check("abort_data0", 64'(seen[0].data), 64'(exp_writes[0].data));
        end
        check("abort_idle_ready", 64'(bus.in_ready), 64'd0);
        check("abort_idle_hold",  64'(bus.cpu_hold), 64'd1);
        run_load("reload", 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
